mips_fwd_regbank: RTL
=====================

// Module: mips_fwd_regbank
// PURPOSE
//  Parametrised register bank for the pipelined MIPS core, with built-in hazard tracking.
//  - Tracks destinations of in-flight instructions and generates forwarding selects itself.
//  - Raises load-use stall; writes back from the WB stage.
//  - Sits between decode and EX; drives EX operands A/B and stalls PM/decode.
// PARAMETERS
//  DATA_W    16  operand/result width
//  NREG      32  number of architectural registers; AW = $clog2(NREG)
//  ZERO_REG  1   1: register 0 reads 0, is never written, never forwarded
// PORTS
//  clk      in   1       rising-edge clock
//  reset    in   1       synchronous, active-high
//  id_valid in   1       decode holds a valid instruction
//  rs       in   AW      source A register
//  rt       in   AW      source B register
//  rd       in   AW      destination register
//  wr_en    in   1       instruction writes rd
//  is_load  in   1       result available only at DM stage (load)
//  use_rs   in   1       instruction reads rs
//  use_rt   in   1       instruction reads rt
//  imm_sel  in   1       B operand is imm instead of rt
//  imm      in   DATA_W  immediate operand
//  ans_ex   in   DATA_W  registered EX result
//  ans_dm   in   DATA_W  registered DM result
//  ans_wb   in   DATA_W  registered WB result; written to bank
//  A        out  DATA_W  EX operand A
//  B        out  DATA_W  EX operand B
//  stall    out  1       combinational load-use stall to PM/decode
// BEHAVIOUR
//  Tag pipeline: slots e0..e3, each {v, rd, wr, ld}.
//  - e0 = instruction currently in EX.
//  - e1 = owner of ans_ex; e2 = owner of ans_dm; e3 = owner of ans_wb.
//  - Every edge: e3<=e2, e2<=e1, e1<=e0.
//  - e0 <= {id_valid&~stall, rd, wr_en, is_load}.
//  - Bubble (stall or ~id_valid): e0.v = 0.
//  Match(x, r): x.v & x.wr & x.rd==r & ~(ZERO_REG & r==0).
//  Writeback:
//  - Every edge: if Match(e3, e3.rd), then bank[e3.rd] <= ans_wb.
//  Issue (edge with id_valid & ~stall), per operand r = rs (A), rt (B):
//  - First match wins; distance-1 priority over older slots.
//  - Match(e0,r) -> sel=EX; Match(e1,r) -> sel=DM; Match(e2,r) -> sel=WB.
//  - Match(e3,r) -> latch ans_wb (write-through bypass).
//  - Else latch bank[r]; r==0 with ZERO_REG -> latch 0.
//  - B with imm_sel=1 -> latch imm, sel=REG, regardless of rt.
//  - Unused operands (use_rs/use_rt=0) take sel=REG.
//  Outputs, combinational after the select register:
//  - sel EX -> ans_ex; DM -> ans_dm; WB -> ans_wb; REG -> latched value.
//  - Forwarding latency 0; operand registers have 1-cycle latency from decode.
//  Load-use stall:
//  - stall = id_valid & e0.v & e0.ld & e0.wr & ((use_rs & Match(e0,rs)) | (use_rt & ~imm_sel & Match(e0,rt))).
//  - During stall: A/B/sel registers hold; e0 gets a bubble.
//  - Next cycle the producer is in e1; the repeated issue selects DM.
//  - A load never stalls more than 1 cycle per dependence.
//  Without stall, every issued instruction advances one slot per cycle.
//  - Back-to-back ALU dependences never stall.
//  Reset (synchronous):
//  - All tags invalid; bank cleared to 0; A/B registers 0; sels REG.
//  - Hence A=B=0 and stall=0 in the cycle after reset.
//  - Reset mid-pipeline discards in-flight tags; no writeback occurs on the reset edge.
//  - reset has priority over all other events.
//  Simultaneous writeback and issue to the same register: issue sees the new value via the e3 bypass.
//  No arithmetic here; all values pass through at DATA_W width.
// TESTING
//  1. Forward via EX: reset; wb r3=7. Then ADD r5<-r3,r3 with ans_ex=14; next issue SUB r6<-r5,r3 -> A=ans_ex=14, B=7, stall=0.
//  2. Forward via DM: dependence at distance 2 -> A tracks ans_dm; distance 3 -> ans_wb; distance 4 -> bank value.
//  3. Load-use: LW r4; next instr uses r4 -> stall=1 for exactly 1 cycle, e0 bubble; then A=ans_dm.
//     - Same with imm_sel=1 on rt -> no stall.
//  4. Zero reg: write r0=0xFFFF and issue a reader of r0 -> A=0, no forwarding, no stall (ZERO_REG=1).
//  5. Same-edge bypass: e3 writes r9=0x1234 on the edge where r9 is issued -> A=0x1234.
//  6. Reset with in-flight writes -> bank all 0, A=B=0, stall=0; rerun at DATA_W=32, NREG=16.

Source files
------------

// File: rtl/mips_fwd_regbank.sv
// mips_fwd_regbank
//   Register bank for the pipelined MIPS core with built-in hazard tracking.
//   A four-slot tag pipeline (e0..e3) follows every issued instruction from EX
//   to WB. The bank uses these tags to pick operand sources, detect load-use
//   hazards and perform writeback.
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   id_valid          : decode holds a valid instruction
//   rs, rt, rd        : source A, source B and destination register numbers
//   wr_en, is_load    : instruction writes rd / result is ready only at DM
//   use_rs, use_rt    : instruction reads rs / rt
//   imm_sel, imm      : B operand is the immediate instead of rt
//   ans_ex/dm/wb      : registered results owned by slots e1/e2/e3
//   A, B              : EX operands (forwarded combinationally, 0 latency)
//   stall             : combinational load-use stall to PM/decode
module mips_fwd_regbank #(
   parameter int DATA_W   = 16,
   parameter int NREG     = 32,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [AW-1:0]     rs,
   input  logic [AW-1:0]     rt,
   input  logic [AW-1:0]     rd,
   input  logic              wr_en,
   input  logic              is_load,
   input  logic              use_rs,
   input  logic              use_rt,
   input  logic              imm_sel,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] ans_dm,
   input  logic [DATA_W-1:0] ans_wb,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              stall
);

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rd;
      logic          wr;
      logic          ld;
   } tag_t;

   typedef enum logic [1:0] {SEL_REG, SEL_EX, SEL_DM, SEL_WB} sel_e;

   tag_t              e_q    [4];
   tag_t              e_d    [4];
   logic [DATA_W-1:0] bank_q [NREG];
   logic [DATA_W-1:0] bank_d [NREG];
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
   sel_e              sel_a_q, sel_a_d, sel_b_q, sel_b_d;
   logic [DATA_W-1:0] bank_rs, bank_rt;
   logic              issue;

   function automatic logic is_zero(input logic [AW-1:0] r);
      return ZERO_REG && (r == '0);
   endfunction

   function automatic logic match(input tag_t x, input logic [AW-1:0] r);
      return x.v && x.wr && (x.rd == r) && !is_zero(r);
   endfunction

   // Youngest producer wins. A producer in e3 is being written back on this
   // very edge, so its ans_wb is captured directly instead of the stale bank.
   function automatic void resolve(
      input  logic [AW-1:0]     r,
      input  tag_t              t0,
      input  tag_t              t1,
      input  tag_t              t2,
      input  tag_t              t3,
      input  logic [DATA_W-1:0] bank_val,
      input  logic [DATA_W-1:0] wb_val,
      output sel_e              sel,
      output logic [DATA_W-1:0] val
   );
      sel = SEL_REG;
      val = '0;
      if (match(t0, r))      sel = SEL_EX;
      else if (match(t1, r)) sel = SEL_DM;
      else if (match(t2, r)) sel = SEL_WB;
      else if (match(t3, r)) val = wb_val;
      else if (!is_zero(r))  val = bank_val;
   endfunction

   // Load-use stall: only a load sitting in EX cannot be forwarded in time.
   always_comb begin
      stall = id_valid && e_q[0].v && e_q[0].ld && e_q[0].wr &&
              ((use_rs && match(e_q[0], rs)) ||
               (use_rt && !imm_sel && match(e_q[0], rt)));
   end

   always_comb begin
      bank_rs = '0;
      bank_rt = '0;
      if (int'(rs) < NREG) bank_rs = bank_q[rs];
      if (int'(rt) < NREG) bank_rt = bank_q[rt];
   end

   assign issue = id_valid && !stall;

   always_comb begin
      e_d[0] = {issue, rd, wr_en, is_load};
      e_d[1] = e_q[0];
      e_d[2] = e_q[1];
      e_d[3] = e_q[2];

      bank_d = bank_q;
      if (match(e_q[3], e_q[3].rd) && (int'(e_q[3].rd) < NREG))
         bank_d[e_q[3].rd] = ans_wb;

      a_d     = a_q;
      b_d     = b_q;
      sel_a_d = sel_a_q;
      sel_b_d = sel_b_q;
      if (issue) begin
         resolve(rs, e_q[0], e_q[1], e_q[2], e_q[3], bank_rs, ans_wb, sel_a_d, a_d);
         resolve(rt, e_q[0], e_q[1], e_q[2], e_q[3], bank_rt, ans_wb, sel_b_d, b_d);
         if (!use_rs) begin
            sel_a_d = SEL_REG;
            a_d     = '0;
         end
         if (imm_sel) begin
            sel_b_d = SEL_REG;
            b_d     = imm;
         end else if (!use_rt) begin
            sel_b_d = SEL_REG;
            b_d     = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q     <= '{default: '0};
         bank_q  <= '{default: '0};
         a_q     <= '0;
         b_q     <= '0;
         sel_a_q <= SEL_REG;
         sel_b_q <= SEL_REG;
      end else begin
         e_q     <= e_d;
         bank_q  <= bank_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sel_a_q <= sel_a_d;
         sel_b_q <= sel_b_d;
      end
   end

   always_comb begin
      unique case (sel_a_q)
         SEL_EX:  A = ans_ex;
         SEL_DM:  A = ans_dm;
         SEL_WB:  A = ans_wb;
         default: A = a_q;
      endcase
      unique case (sel_b_q)
         SEL_EX:  B = ans_ex;
         SEL_DM:  B = ans_dm;
         SEL_WB:  B = ans_wb;
         default: B = b_q;
      endcase
   end

endmodule
